posit_fraction_normalizer: RTL and testbench

Multi-cycle normalizer and rounder for posit fraction paths: the counterpart of the right-shift/sticky alignment stage. It accepts an aligned, possibly denormalized fraction whose two LSBs are guard and sticky. It left-shifts the fraction until its MSB is 1, counting the shifts, then applies round-to-nearest-even. It sits after the fraction adder/subtractor and feeds the exponent adjust and posit encode stages through a valid/ready handshake on both sides.

---
 rtl/posit_fraction_normalizer.sv | 114 +++++++++++
 tb/tb_posit_fraction_normalizer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/posit_fraction_normalizer.sv
// Multi-cycle posit fraction normalizer: left-shifts an aligned fraction until its MSB
// is set, counting the shifts, then rounds to nearest-even on the guard/sticky bits.
module posit_fraction_normalizer #(
    parameter  int N  = 8,
    parameter  int es = 4,
    localparam int W  = N - es + 3,
    localparam int M  = W - 2,
    localparam int CW = $clog2(W) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         A,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [M-1:0]         Z,
    output logic signed [CW-1:0] shift_cnt,
    output logic                 zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic signed [CW-1:0] CNT_ONE = CW'(1);

    state_t                 state_q;
    logic [W-1:0]           t_q;
    logic signed [CW-1:0]   cnt_q;
    logic [M-1:0]           z_q;
    logic signed [CW-1:0]   sc_q;
    logic                   zero_q;
    logic                   out_valid_q;

    logic [M-1:0]           mant_d;
    logic                   up_d;
    logic [M:0]             sum_d;

    // Round-to-nearest-even: round up on guard unless it is an exact tie with an even mantissa.
    always_comb begin
        mant_d = t_q[W-1:2];
        up_d   = t_q[1] & (t_q[0] | t_q[2]);
        sum_d  = {1'b0, mant_d} + {{M{1'b0}}, up_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            t_q         <= '0;
            cnt_q       <= '0;
            z_q         <= '0;
            sc_q        <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        t_q   <= A;
                        cnt_q <= '0;
                        if (A == '0) begin
                            z_q         <= '0;
                            sc_q        <= '0;
                            zero_q      <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (t_q[W-1]) begin
                        state_q <= ROUND;
                    end else begin
                        t_q   <= {t_q[W-2:0], 1'b0};
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ROUND: begin
                    // Carry out of the mantissa renormalizes by one position to the right.
                    if (sum_d[M]) begin
                        z_q  <= {1'b1, {(M-1){1'b0}}};
                        sc_q <= cnt_q - CNT_ONE;
                    end else begin
                        z_q  <= sum_d[M-1:0];
                        sc_q <= cnt_q;
                    end
                    zero_q      <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign Z         = z_q;
    assign shift_cnt = sc_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_posit_fraction_normalizer.sv
// Directed self-checking bench for posit_fraction_normalizer at default parameters
// (W=7, M=5, CW=4); inputs driven and outputs sampled on the falling edge.
module tb_posit_fraction_normalizer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] A;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] Z;
    logic [3:0] shift_cnt;
    logic       zero;

    int tests  = 0;
    int failed = 0;

    posit_fraction_normalizer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Z         (Z),
        .shift_cnt (shift_cnt),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Present one operand, measure falling edges from the accept edge to out_valid,
    // check the result, then complete the output handshake.
    task automatic run_op(input string tag, input logic [6:0] a_v, input logic [4:0] exp_z,
                          input logic [3:0] exp_sc, input logic exp_zero, input int exp_lat);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        A        = a_v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        A        = '0;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_Z"}, 32'(Z), 32'(exp_z));
        check({tag, "_shift_cnt"}, 32'(shift_cnt), 32'(exp_sc));
        check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_rise"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [4:0] held_z;
        logic [3:0] held_sc;
        int         lat;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_Z", 32'(Z), 32'd0);
        check("rst_shift_cnt", 32'(shift_cnt), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);

        run_op("lz3",      7'b0001011, 5'b10110, 4'd3,    1'b0, 5);
        run_op("rnd_up",   7'b1011011, 5'b10111, 4'd0,    1'b0, 2);
        run_op("tie_even", 7'b1011010, 5'b10110, 4'd0,    1'b0, 2);
        run_op("tie_odd",  7'b1011110, 5'b11000, 4'd0,    1'b0, 2);
        run_op("rnd_ovf",  7'b1111110, 5'b10000, 4'b1111, 1'b0, 2);
        // Zero goes straight to DONE, so out_valid is already up in the cycle after accept.
        run_op("zero",     7'b0000000, 5'b00000, 4'd0,    1'b1, 0);
        run_op("lz6",      7'b0000001, 5'b10000, 4'd6,    1'b0, 8);

        // Backpressure: result held while a competing operand is offered.
        A        = 7'b0001011;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 32'(lat), 32'd5);
        held_z   = 5'b10110;
        held_sc  = 4'd3;
        A        = 7'b1111110;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_Z", 32'(Z), 32'(held_z));
            check("bp_shift_cnt", 32'(shift_cnt), 32'(held_sc));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);

        // Reset mid-NORM discards the operand in flight.
        A        = 7'b0000001;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midnorm_busy", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_Z", 32'(Z), 32'd0);
        check("mr_shift_cnt", 32'(shift_cnt), 32'd0);
        check("mr_zero", 32'(zero), 32'd0);

        run_op("post_rst", 7'b0011000, 5'b11000, 4'd2, 1'b0, 4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
